ppi_rw_control: RTL

- Read/write control logic that sequences the 8-bit data bus buffer of the PPI.
- Synchronises the asynchronous host strobes (CS, RD, WR) to CLK and decodes A[1:0].
- On reads: drives the buffer's Data_out byte and read-enable.
- On writes: commits the host byte into port A/B/C output registers or the control word register.
- Sits between the host-side pins and the port registers; owns all bus-cycle sequencing.

---
 rtl/ppi_pkg.sv | 19 +
 rtl/ppi_sync_bit.sv | 23 ++
 rtl/ppi_rw_control.sv | 136 +++++++++++++
 3 files changed

// File: rtl/ppi_pkg.sv
// Shared types and constants for the PPI read/write control slice.
package ppi_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RD_CYC,
        WR_CYC,
        WAIT_REL
    } ppi_state_e;

    localparam logic [1:0] ADDR_PA   = 2'd0;
    localparam logic [1:0] ADDR_PB   = 2'd1;
    localparam logic [1:0] ADDR_PC   = 2'd2;
    localparam logic [1:0] ADDR_CTRL = 2'd3;

    localparam logic [7:0]  CTRL_DEFAULT = 8'h9B;
    localparam int unsigned MODE_BIT     = 7;

endpackage

// File: rtl/ppi_sync_bit.sv
// Multi-stage synchroniser for one asynchronous active-low strobe; presets to 1.
module ppi_sync_bit #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] ff_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff_q <= '1;
        end else begin
            ff_q <= {ff_q[SYNC_STAGES-2:0], d};
        end
    end

    assign q = ff_q[SYNC_STAGES-1];

endmodule

// File: rtl/ppi_rw_control.sv
// PPI bus-cycle sequencer: strobe sync, read mux, write commit to port/control registers.
// Define PPI_BSR_EN to make control writes with D7=0 act as port C bit set/reset.
module ppi_rw_control
    import ppi_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [7:0]  CTRL_RESET  = CTRL_DEFAULT
) (
    input  logic       CLK,
    input  logic       RST_n,
    input  logic       CS,
    input  logic       RD,
    input  logic       WR,
    input  logic [1:0] A,
    input  logic [7:0] DIN,
    input  logic [7:0] PA_IN,
    input  logic [7:0] PB_IN,
    input  logic [7:0] PC_IN,
    output logic [7:0] Data_out,
    output logic       RD_EN,
    output logic [7:0] PA_OUT,
    output logic [7:0] PB_OUT,
    output logic [7:0] PC_OUT,
    output logic [7:0] CTRL_WORD,
    output logic       BUS_ERR
);

    logic cs_s, rd_s, wr_s;

    ppi_sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
        .clk(CLK), .rst_n(RST_n), .d(CS), .q(cs_s)
    );
    ppi_sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync_rd (
        .clk(CLK), .rst_n(RST_n), .d(RD), .q(rd_s)
    );
    ppi_sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync_wr (
        .clk(CLK), .rst_n(RST_n), .d(WR), .q(wr_s)
    );

    ppi_state_e state_q;
    logic [1:0] addr_q;
    logic [7:0] hold_q;
    logic [1:0] rd_addr;
    logic [7:0] rd_data;

    // In IDLE the live address selects the first byte; afterwards the latched one does.
    always_comb begin
        rd_addr = (state_q == IDLE) ? A : addr_q;
        case (rd_addr)
            ADDR_PA: rd_data = PA_IN;
            ADDR_PB: rd_data = PB_IN;
            ADDR_PC: rd_data = PC_IN;
            default: rd_data = CTRL_WORD;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q   <= IDLE;
            addr_q    <= ADDR_PA;
            hold_q    <= '0;
            Data_out  <= '0;
            RD_EN     <= 1'b0;
            PA_OUT    <= '0;
            PB_OUT    <= '0;
            PC_OUT    <= '0;
            CTRL_WORD <= CTRL_RESET;
            BUS_ERR   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!cs_s) begin
                        if (!rd_s && wr_s) begin
                            state_q  <= RD_CYC;
                            addr_q   <= A;
                            Data_out <= rd_data;
                            RD_EN    <= 1'b1;
                            BUS_ERR  <= 1'b0;
                        end else if (rd_s && !wr_s) begin
                            state_q <= WR_CYC;
                            addr_q  <= A;
                            hold_q  <= DIN;
                            BUS_ERR <= 1'b0;
                        end else if (!rd_s && !wr_s) begin
                            state_q <= WAIT_REL;
                            BUS_ERR <= 1'b1;
                        end
                    end
                end
                RD_CYC: begin
                    if (rd_s || cs_s) begin
                        state_q <= IDLE;
                        RD_EN   <= 1'b0;
                    end else begin
                        Data_out <= rd_data;
                    end
                end
                WR_CYC: begin
                    if (cs_s) begin
                        // Chip deselected before the strobe closed: drop the write.
                        state_q <= IDLE;
                    end else if (wr_s) begin
                        state_q <= IDLE;
                        case (addr_q)
                            ADDR_PA: PA_OUT <= hold_q;
                            ADDR_PB: PB_OUT <= hold_q;
                            ADDR_PC: PC_OUT <= hold_q;
                            default: begin
                                if (hold_q[MODE_BIT]) begin
                                    CTRL_WORD <= hold_q;
                                    PA_OUT    <= '0;
                                    PB_OUT    <= '0;
                                    PC_OUT    <= '0;
                                end
`ifdef PPI_BSR_EN
                                else begin
                                    PC_OUT[hold_q[3:1]] <= hold_q[0];
                                end
`endif
                            end
                        endcase
                    end else begin
                        hold_q <= DIN;
                    end
                end
                WAIT_REL: begin
                    if (rd_s && wr_s) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
